// File: rtl/router_pkg.sv
// Shared definitions for the router input unit: flit types, field positions
// and small decode helpers.
package router_pkg;

  localparam int FLIT_W_DEF   = 34;
  localparam int NUM_OUT      = 2;
  localparam int TYPE_W       = 2;
  // Type occupies the top TYPE_W bits; dest sits directly below it.
  localparam int TYPE_TOP_OFS = 1;
  localparam int DEST_TOP_OFS = 3;

  typedef enum logic [1:0] {
    FT_BODY      = 2'b00,
    FT_TAIL      = 2'b01,
    FT_HEAD      = 2'b10,
    FT_HEAD_TAIL = 2'b11
  } flit_type_t;

  function automatic logic is_head_type(input flit_type_t t);
    return (t == FT_HEAD) || (t == FT_HEAD_TAIL);
  endfunction

  function automatic logic [NUM_OUT-1:0] route_onehot(input logic dest);
    return dest ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/router_input_fifo.sv
// Flit buffer for one router input: circular storage, wrapping pointers and
// an occupancy counter. Push is refused when full; pop is ignored when empty.
module router_input_fifo
  import router_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_data,
  input  logic              pop,
  output logic [FLIT_W-1:0] head_data,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Flit storage; contents need no reset because empty slots are never observed as valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/router_input_unit.sv
// Router input unit: buffers incoming flits, requests the output selected by
// the packet head, holds that route until the tail leaves, and drops flits
// that arrive outside a packet while flagging a sticky protocol error.
module router_input_unit
  import router_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FLIT_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [NUM_OUT-1:0] request,
  input  logic [NUM_OUT-1:0] grant,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [FLIT_W-1:0]  out_data,
  output logic [NUM_OUT-1:0] out_valid,
  output logic               forwarding_head,
  output logic               forwarding_tail,
  output logic               proto_error
);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               route_q, route_d;
  logic               proto_q;
  logic               proto_set;
  logic [FLIT_W-1:0]  head_flit;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               drop;
  logic [NUM_OUT-1:0] xfer;
  flit_type_t         head_type;
  logic               head_dest;

  assign in_ready    = !fifo_full;
  assign out_data    = head_flit;
  assign proto_error = proto_q;
  assign head_type   = flit_type_t'(head_flit[FLIT_W-TYPE_TOP_OFS -: TYPE_W]);
  assign head_dest   = head_flit[FLIT_W-DEST_TOP_OFS];
  assign pop         = (|xfer) || drop;

  router_input_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .head_data (head_flit),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Request generation, transfer detection, stray-flit dropping and next-state decode.
  always_comb begin
    request         = '0;
    xfer            = '0;
    out_valid       = '0;
    forwarding_head = 1'b0;
    forwarding_tail = 1'b0;
    drop            = 1'b0;
    proto_set       = 1'b0;
    state_d         = state_q;
    route_d         = route_q;

    if (state_q == ST_IDLE) begin
      if (!fifo_empty) begin
        if (is_head_type(head_type)) begin
          request = route_onehot(head_dest);
        end else begin
          drop      = 1'b1;
          proto_set = 1'b1;
        end
      end
    end else begin
      // Route is pinned for the whole packet, even while the buffer runs dry.
      request = route_onehot(route_q);
      if (!fifo_empty && is_head_type(head_type)) proto_set = 1'b1;
    end

    xfer      = request & grant & out_ready & {NUM_OUT{!fifo_empty}};
    out_valid = xfer;

    if (|xfer) begin
      if (state_q == ST_IDLE) begin
        forwarding_head = 1'b1;
        forwarding_tail = (head_type == FT_HEAD_TAIL);
        if (head_type == FT_HEAD) begin
          state_d = ST_ACTIVE;
          route_d = head_dest;
        end
      end else if (head_type == FT_TAIL) begin
        forwarding_tail = 1'b1;
        state_d         = ST_IDLE;
      end
    end
  end

  // Packet state, latched route and sticky protocol error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      route_q <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      if (proto_set) proto_q <= 1'b1;
    end
  end

  a_req_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(request));
  a_vld_onehot : assert property (@(posedge clk) disable iff (!rst) $onehot0(out_valid));
  a_req_stable : assert property (@(posedge clk) disable iff (!rst)
                   (state_q == ST_ACTIVE) |=> ((state_q != ST_ACTIVE) || $stable(request)));

endmodule

// File: tb/tb_router_input_unit.sv
// Bench for router_input_unit: directed packet scenarios followed by a random
// flit stream, all compared against a queue-based packet model.
module tb_router_input_unit;

  localparam int FLIT_W = 34;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic [FLIT_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        request;
  logic [1:0]        grant;
  logic [1:0]        out_ready;
  logic [FLIT_W-1:0] out_data;
  logic [1:0]        out_valid;
  logic              forwarding_head;
  logic              forwarding_tail;
  logic              proto_error;

  int checks = 0;
  int errors = 0;

  // Reference model: buffered flits, packet-in-progress flag, route, sticky error.
  logic [FLIT_W-1:0] mq[$];
  bit                m_active;
  bit                m_route;
  bit                m_proto;

  router_input_unit #(.FLIT_W(FLIT_W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .request         (request),
    .grant           (grant),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .forwarding_head (forwarding_head),
    .forwarding_tail (forwarding_tail),
    .proto_error     (proto_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input bit dest, input int p);
    logic [FLIT_W-4:0] pl;
    pl = p[FLIT_W-4:0];
    return {t, dest, pl};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_active = 1'b0;
    m_route  = 1'b0;
    m_proto  = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_request"}, request, 2'b00);
    check({tag, "_out_valid"}, out_valid, 2'b00);
    check({tag, "_fwd_head"}, forwarding_head, 1'b0);
    check({tag, "_fwd_tail"}, forwarding_tail, 1'b0);
    check({tag, "_proto"}, proto_error, 1'b0);
  endtask

  // One clock cycle: drive, compare against model at negedge, advance model at posedge.
  task automatic cycle(input bit v, input logic [FLIT_W-1:0] d, input logic [1:0] g,
                       input logic [1:0] ordy, output bit acc);
    bit                ne, e_rdy, e_fwd, e_drop, e_fh, e_ft, was_active;
    logic [FLIT_W-1:0] hd;
    logic [1:0]        t, e_req, e_ov;
    bit                dd;
    in_valid  = v;
    in_data   = d;
    grant     = g;
    out_ready = ordy;
    @(negedge clk);
    ne     = (mq.size() > 0);
    hd     = ne ? mq[0] : '0;
    t      = hd[FLIT_W-1 -: 2];
    dd     = hd[FLIT_W-3];
    e_rdy  = (mq.size() < DEPTH);
    if (m_active)          e_req = 2'b01 << m_route;
    else if (ne && t[1])   e_req = 2'b01 << dd;
    else                   e_req = 2'b00;
    e_fwd  = ne && ((e_req & g & ordy) != 2'b00);
    e_ov   = e_fwd ? e_req : 2'b00;
    e_drop = !m_active && ne && !t[1];
    e_fh   = e_fwd && !m_active;
    e_ft   = e_fwd && (m_active ? (t == 2'b01) : (t == 2'b11));
    check("in_ready", in_ready, e_rdy);
    check("request", request, e_req);
    check("out_valid", out_valid, e_ov);
    check("fwd_head", forwarding_head, e_fh);
    check("fwd_tail", forwarding_tail, e_ft);
    check("proto_error", proto_error, m_proto);
    if (ne) check("out_data", out_data, hd);
    @(posedge clk);
    was_active = m_active;
    if (ne && (was_active ? t[1] : !t[1])) m_proto = 1'b1;
    if (e_fwd && !was_active && t == 2'b10) begin
      m_active = 1'b1;
      m_route  = dd;
    end
    if (e_fwd && was_active && t == 2'b01) m_active = 1'b0;
    if (e_fwd || e_drop) void'(mq.pop_front());
    acc = v && e_rdy;
    if (acc) mq.push_back(d);
    #1;
  endtask

  // Asynchronous reset pulse spanning one rising edge, checked before any clock arrives.
  task automatic async_reset(input string tag);
    #2 rst = 1'b0;
    #1;
    model_clear();
    check_quiet({tag, "_imm"});
    @(posedge clk);
    #1;
    check_quiet({tag, "_hold"});
    rst = 1'b1;
  endtask

  initial begin
    bit                acc;
    bit                have, gen_in_pkt, v;
    logic [FLIT_W-1:0] pend;
    logic [1:0]        ty;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    grant     = 2'b00;
    out_ready = 2'b00;
    model_clear();
    #2;
    check_quiet("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single-flit packet to output 1.
    cycle(1, mk(2'b11, 1, 32'h11), 2'b10, 2'b11, acc);
    cycle(0, '0, 2'b10, 2'b11, acc);
    cycle(0, '0, 2'b10, 2'b11, acc);

    // Four-flit packet to output 0 with grant held.
    cycle(1, mk(2'b10, 0, 32'h21), 2'b01, 2'b11, acc);
    cycle(1, mk(2'b00, 0, 32'h22), 2'b01, 2'b11, acc);
    cycle(1, mk(2'b00, 0, 32'h23), 2'b01, 2'b11, acc);
    cycle(1, mk(2'b01, 0, 32'h24), 2'b01, 2'b11, acc);
    for (int i = 0; i < 3; i++) cycle(0, '0, 2'b01, 2'b11, acc);

    // Fill to full with downstream stalled; the fifth flit must be refused.
    cycle(1, mk(2'b10, 1, 32'h31), 2'b10, 2'b00, acc);
    cycle(1, mk(2'b00, 1, 32'h32), 2'b10, 2'b00, acc);
    cycle(1, mk(2'b00, 1, 32'h33), 2'b10, 2'b00, acc);
    cycle(1, mk(2'b01, 1, 32'h34), 2'b10, 2'b00, acc);
    cycle(1, mk(2'b11, 0, 32'h35), 2'b10, 2'b00, acc);
    check("fifth_refused", acc, 1'b0);
    for (int i = 0; i < 5; i++) cycle(0, '0, 2'b10, 2'b10, acc);

    // Head leaves, buffer runs dry, tail arrives later.
    cycle(1, mk(2'b10, 1, 32'h41), 2'b10, 2'b10, acc);
    cycle(0, '0, 2'b10, 2'b10, acc);
    for (int i = 0; i < 3; i++) cycle(0, '0, 2'b11, 2'b11, acc);
    cycle(1, mk(2'b01, 1, 32'h42), 2'b10, 2'b10, acc);
    cycle(0, '0, 2'b10, 2'b10, acc);
    cycle(0, '0, 2'b10, 2'b10, acc);

    // Stray body flit while idle: dropped, error sticks until reset.
    cycle(1, mk(2'b00, 0, 32'h51), 2'b11, 2'b11, acc);
    for (int i = 0; i < 3; i++) cycle(0, '0, 2'b11, 2'b11, acc);
    async_reset("rst_proto");

    // Reset with a partial packet buffered; nothing may leave afterwards.
    cycle(1, mk(2'b10, 0, 32'h61), 2'b01, 2'b00, acc);
    cycle(1, mk(2'b00, 0, 32'h62), 2'b01, 2'b00, acc);
    cycle(1, mk(2'b00, 0, 32'h63), 2'b01, 2'b00, acc);
    cycle(0, '0, 2'b01, 2'b00, acc);
    async_reset("rst_mid");
    for (int i = 0; i < 3; i++) cycle(0, '0, 2'b11, 2'b11, acc);
    cycle(1, mk(2'b11, 0, 32'h64), 2'b01, 2'b01, acc);
    cycle(0, '0, 2'b01, 2'b01, acc);

    // Random packet stream with occasional protocol violations and random backpressure.
    have       = 1'b0;
    gen_in_pkt = 1'b0;
    pend       = '0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        async_reset("rst_rand");
        have       = 1'b0;
        gen_in_pkt = 1'b0;
      end
      if (!have) begin
        if ($urandom_range(0, 19) == 0)  ty = 2'($urandom_range(0, 3));
        else if (!gen_in_pkt)            ty = ($urandom_range(0, 9) < 7) ? 2'b10 : 2'b11;
        else                             ty = ($urandom_range(0, 9) < 3) ? 2'b01 : 2'b00;
        if (ty == 2'b10) gen_in_pkt = 1'b1;
        if (ty == 2'b01 || ty == 2'b11) gen_in_pkt = 1'b0;
        pend = mk(ty, 1'($urandom_range(0, 1)), int'($urandom()));
        have = 1'b1;
      end
      v = ($urandom_range(0, 3) != 0);
      cycle(v, pend, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), acc);
      if (acc) have = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
